// File: rtl/dma_pkg.sv
// Shared types and widths for the DMA byte aligner.
// Optional DMA_ALIGNER_BSWAP_EN byte-reverses each source qword.
package dma_pkg;

  localparam int QW_W  = 64;
  localparam int OFF_W = 3;
  localparam int CNT_W = 14;
  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  function automatic logic [QW_W-1:0] bswap64(
    input logic [QW_W-1:0] d
  );
    logic [QW_W-1:0] r;
    for (int j = 0; j < 8; j++)
      r[8*j +: 8] = d[8*(7-j) +: 8];
    return r;
  endfunction

endpackage

// File: rtl/dma_byte_shifter.sv
// Picks a 64-bit qword out of a 128-bit window.
// sh=0 selects the upper qword; each step moves one byte lower.
module dma_byte_shifter
  import dma_pkg::*;
(
  input  logic [2*QW_W-1:0] win,
  input  logic [OFF_W-1:0]  sh,
  output logic [QW_W-1:0]   q
);

  logic [7:0] amt;

  assign amt = 8'd64 - {2'b00, sh, 3'b000};
  assign q   = QW_W'(win >> amt);

endmodule

// File: rtl/dma_aligner.sv
// Realigns a source qword stream to a destination byte offset.
// DMA_ALIGNER_BSWAP_EN: byte-reverse each accepted in_data first.
module dma_aligner
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  input  logic [31:0]       src_addr,
  input  logic [31:0]       dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [QW_W-1:0]   in_data,
  input  logic              in_en,
  output logic              in_ready,
  output logic [QW_W-1:0]   data,
  output logic              data_en,
  input  logic              stall
);

  state_e            state;
  logic [CNT_W-1:0]  nin;
  logic [CNT_W-1:0]  nout;
  logic [CNT_W-1:0]  in_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic [OFF_W-1:0]  shamt;
  logic [OFF_W-1:0]  dst_off;
  logic              m_off;
  logic [16:0]       end_pos;
  logic [QW_W-1:0]   hi;
  logic [QW_W-1:0]   lo;

  logic [OFF_W-1:0]  src_o;
  logic [OFF_W-1:0]  dst_o;
  logic [16:0]       nin_sum;
  logic [16:0]       nout_sum;
  logic [CNT_W:0]    win_top;
  logic [CNT_W:0]    need;
  logic [CNT_W-1:0]  fill_need;
  logic [CNT_W-1:0]  in_nxt;
  logic [CNT_W-1:0]  out_nxt;
  logic              out_ok;
  logic              fire;
  logic              acc;
  logic [QW_W-1:0]   din;
  logic [2*QW_W-1:0] win;
  logic [QW_W-1:0]   sq;
  logic [16:0]       pos;
  logic              unused_bits;

  assign src_o = src_addr[2:0];
  assign dst_o = dst_addr[2:0];

  assign nin_sum  = {14'd0, src_o} + {1'b0, length} + 17'd7;
  assign nout_sum = {14'd0, dst_o} + {1'b0, length} + 17'd7;

  assign unused_bits = ^{src_addr[31:3], dst_addr[31:3],
                         nin_sum[2:0], nout_sum[2:0]};

`ifdef DMA_ALIGNER_BSWAP_EN
  assign din = bswap64(in_data);
`else
  assign din = in_data;
`endif

  // window for output k is {in[k+m_off], in[k+m_off-1]}
  assign win_top = {1'b0, out_cnt}
                 + {{CNT_W{1'b0}}, m_off} + 15'd1;
  assign need = (win_top < {1'b0, nin}) ?
                win_top : {1'b0, nin};
  assign fill_need = (m_off && nin > 14'd1) ?
                     14'd2 : 14'd1;

  assign out_ok = start
               && (state == S_RUN || state == S_FLUSH)
               && out_cnt < nout
               && {1'b0, in_cnt} >= need;
  assign fire    = out_ok && !stall;
  assign data_en = fire;

  assign in_ready = start
                 && (state == S_FILL || state == S_RUN)
                 && in_cnt < nin
                 && ({1'b0, in_cnt} < win_top || fire);
  assign acc = in_ready && in_en;

  assign in_nxt  = acc  ? in_cnt + 14'd1  : in_cnt;
  assign out_nxt = fire ? out_cnt + 14'd1 : out_cnt;

  assign win = ({1'b0, in_cnt} == win_top) ?
               {hi, lo} : {{QW_W{1'b0}}, hi};

  dma_byte_shifter u_shift (
    .win (win),
    .sh  (shamt),
    .q   (sq)
  );

  always_comb begin
    data = '0;
    pos  = '0;
    if (out_ok) begin
      for (int j = 0; j < 8; j++) begin
        pos = {out_cnt, 3'(j)};
        if (pos >= {14'd0, dst_off} && pos < end_pos)
          data[8*j +: 8] = sq[8*j +: 8];
      end
    end
  end

  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      nin     <= '0;
      nout    <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      shamt   <= '0;
      dst_off <= '0;
      m_off   <= 1'b0;
      end_pos <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (!start) begin
      state   <= S_IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (acc) begin
        hi     <= din;
        lo     <= hi;
        in_cnt <= in_nxt;
      end
      if (fire)
        out_cnt <= out_nxt;
      unique case (state)
        S_IDLE: begin
          nin     <= nin_sum[16:3];
          nout    <= nout_sum[16:3];
          shamt   <= dst_o - src_o;
          m_off   <= (src_o > dst_o);
          dst_off <= dst_o;
          end_pos <= {14'd0, dst_o} + {1'b0, length};
          in_cnt  <= '0;
          out_cnt <= '0;
          hi      <= '0;
          lo      <= '0;
          state   <= S_FILL;
        end
        S_FILL: begin
          if (in_nxt >= fill_need)
            state <= S_RUN;
        end
        S_RUN, S_FLUSH: begin
          if (out_nxt == nout)
            state <= S_DONE;
          else if (in_nxt == nin)
            state <= S_FLUSH;
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_aligner.sv
// Directed bench for dma_aligner.
// Build with DMA_ALIGNER_BSWAP_EN to exercise the byte-swap path.
module tb_dma_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        done;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] length;
  logic [63:0] in_data;
  logic        in_en;
  logic        in_ready;
  logic [63:0] data;
  logic        data_en;
  logic        stall;

  int total = 0;
  int bad   = 0;
  int n_in, n_out, bad_stall, first_cyc, last_cyc;
  bit timeout;
  bit use_raw = 1'b0;
  logic [63:0] raw_qw;
  logic [63:0] out_q [16];
  logic [63:0] exp_bs;

  always #5 clk = ~clk;

  dma_aligner dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .done     (done),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .in_data  (in_data),
    .in_en    (in_en),
    .in_ready (in_ready),
    .data     (data),
    .data_en  (data_en),
    .stall    (stall)
  );

  function automatic logic [63:0] swap8(input logic [63:0] d);
    logic [63:0] r;
    for (int j = 0; j < 8; j++)
      r[8*j +: 8] = d[8*(7-j) +: 8];
    return r;
  endfunction

  // payload byte i is 8'h10+i; lanes outside the payload are junk
  function automatic logic [63:0] gen(input int m, input int so,
                                      input int len);
    logic [63:0] q;
    int i;
    for (int l = 0; l < 8; l++) begin
      i = 8*m + l - so;
      q[8*l +: 8] = (i >= 0 && i < len) ? 8'(16 + i) : 8'hEE;
    end
`ifdef DMA_ALIGNER_BSWAP_EN
    return swap8(q);
`else
    return q;
`endif
  endfunction

  function automatic logic [63:0] expq(input int k, input int dof,
                                       input int len);
    logic [63:0] q;
    int i;
    for (int l = 0; l < 8; l++) begin
      i = 8*k + l - dof;
      q[8*l +: 8] = (i >= 0 && i < len) ? 8'(16 + i) : 8'h00;
    end
    return q;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stream(input string tag, input int dof,
                            input int len, input int n);
    for (int k = 0; k < n && k < 16; k++)
      chk($sformatf("%s_q%0d", tag, k), out_q[k], expq(k, dof, len));
  endtask

  task automatic xfer(input int so, input int dof, input int len,
                      input bit rnd, input int drop_after);
    bit ended;
    src_addr  = {29'h0ABCDE1, 3'(so)};
    dst_addr  = {29'h1F0F0F0, 3'(dof)};
    length    = 16'(len);
    n_in      = 0;
    n_out     = 0;
    bad_stall = 0;
    first_cyc = -1;
    last_cyc  = -1;
    timeout   = 1'b0;
    ended     = 1'b0;
    start     = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      stall   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      in_en   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data = use_raw ? raw_qw : gen(n_in, so, len);
      #1;
      if (data_en) begin
        if (stall) bad_stall++;
        if (n_out < 16) out_q[n_out] = data;
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        n_out++;
      end
      if (in_en && in_ready) n_in++;
      if (drop_after > 0 && n_out == drop_after) begin
        ended = 1'b1;
        break;
      end
      if (done) begin
        ended = 1'b1;
        break;
      end
    end
    if (!ended) timeout = 1'b1;
  endtask

  task automatic finish_xfer(input string tag);
    chk({tag, "_done"}, 64'(done), 64'd1);
    @(negedge clk);
    start = 1'b0;
    in_en = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_idle"}, 64'(done), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b1;
    in_en    = 1'b1;
    stall    = 1'b0;
    in_data  = '1;
    src_addr = '0;
    dst_addr = '0;
    length   = 16'd16;
    raw_qw   = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_data", data, 64'd0);
    chk("rst_en", 64'(data_en), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    start = 1'b0;
    in_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_rdy", 64'(in_ready), 64'd0);

    // aligned pass-through
    xfer(0, 0, 16, 1'b0, 0);
    chk("t32_to", 64'(timeout), 64'd0);
    chk("t32_nin", 64'(n_in), 64'd2);
    chk("t32_nout", 64'(n_out), 64'd2);
    chk("t32_q0", out_q[0], 64'h1716151413121110);
    chk("t32_q1", out_q[1], 64'h1F1E1D1C1B1A1918);
    chk("t32_tput", 64'(last_cyc - first_cyc), 64'd1);
    finish_xfer("t32");

    // source ahead of destination: two fills before output
    xfer(3, 0, 16, 1'b0, 0);
    chk("t33_to", 64'(timeout), 64'd0);
    chk("t33_nin", 64'(n_in), 64'd3);
    chk("t33_nout", 64'(n_out), 64'd2);
    chk("t33_q0", out_q[0], 64'h1716151413121110);
    chk("t33_q1", out_q[1], 64'h1F1E1D1C1B1A1918);
    finish_xfer("t33");

    // short payload straddling a destination qword
    xfer(0, 5, 4, 1'b0, 0);
    chk("t34_to", 64'(timeout), 64'd0);
    chk("t34_nin", 64'(n_in), 64'd1);
    chk("t34_nout", 64'(n_out), 64'd2);
    chk("t34_q0", out_q[0], 64'h1211100000000000);
    chk("t34_q1", out_q[1], 64'h0000000000000013);
    finish_xfer("t34");

    // random backpressure and input gaps
    xfer(6, 1, 40, 1'b1, 0);
    chk("t35_to", 64'(timeout), 64'd0);
    chk("t35_nin", 64'(n_in), 64'd6);
    chk("t35_nout", 64'(n_out), 64'd6);
    chk("t35_stall", 64'(bad_stall), 64'd0);
    chk_stream("t35", 1, 40, 6);
    finish_xfer("t35");

    // abort after two outputs, then a clean rerun
    xfer(0, 0, 32, 1'b0, 2);
    chk("t36_nout", 64'(n_out), 64'd2);
    @(negedge clk);
    start = 1'b0;
    in_en = 1'b0;
    #1;
    chk("t36_gate", 64'(data_en), 64'd0);
    @(negedge clk);
    #1;
    chk("t36_en", 64'(data_en), 64'd0);
    chk("t36_rdy", 64'(in_ready), 64'd0);
    chk("t36_done", 64'(done), 64'd0);
    xfer(0, 0, 32, 1'b0, 0);
    chk("t36b_to", 64'(timeout), 64'd0);
    chk("t36b_nin", 64'(n_in), 64'd4);
    chk("t36b_nout", 64'(n_out), 64'd4);
    chk("t36b_tput", 64'(last_cyc - first_cyc), 64'd3);
    chk_stream("t36b", 0, 32, 4);
    finish_xfer("t36b");

    // raw lane order through the optional byte swap
    use_raw = 1'b1;
    raw_qw  = 64'h0706050403020100;
`ifdef DMA_ALIGNER_BSWAP_EN
    exp_bs = 64'h0001020304050607;
`else
    exp_bs = 64'h0706050403020100;
`endif
    xfer(0, 0, 8, 1'b0, 0);
    chk("t37_to", 64'(timeout), 64'd0);
    chk("t37_nout", 64'(n_out), 64'd1);
    chk("t37_q0", out_q[0], exp_bs);
    finish_xfer("t37");
    use_raw = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
